// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core's unified fetch/load/store port.
// Accepts one request at a time over a valid/ready handshake. It waits a fixed,
// parameterised number of cycles and then returns a one-cycle response strobe.
// The word-organised RAM reports misaligned or out-of-range accesses as
// errors, and those accesses never change the RAM.
module mem_responder #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // One bit wider than the address so that the byte limit is representable.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);
  // The counter is loaded with LATENCY-1 so that WAIT lasts exactly LATENCY edges.
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                state_reg;
  state_t                state_next;
  logic [3:0]            cnt_reg;
  logic [3:0]            cnt_next;

  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  write_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;

  logic                  rsp_error_reg;
  logic                  rsp_rd_ok_reg;
  logic [DATA_WIDTH-1:0] ram_rdata_reg;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH_WORDS];

  logic                  accept;
  logic                  enter_resp;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_write;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [IDX_W-1:0]      acc_idx;
  logic                  acc_fault;
  logic                  mem_we;

  assign accept = (state_reg == ST_IDLE) && req_valid;

  // Next-state and wait-counter logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_next = ST_RESP;
          end else begin
            state_next = ST_WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // The RAM is accessed on the edge that enters RESP. With zero latency this
  // is the accept edge itself, so the request is taken straight from the
  // inputs. Otherwise it comes from the copy captured at accept.
  assign enter_resp = (state_next == ST_RESP) && (state_reg != ST_RESP);
  assign acc_addr   = (state_reg == ST_IDLE) ? req_addr  : addr_reg;
  assign acc_write  = (state_reg == ST_IDLE) ? req_write : write_reg;
  assign acc_wdata  = (state_reg == ST_IDLE) ? req_wdata : wdata_reg;
  assign acc_idx    = acc_addr[2 +: IDX_W];
  assign acc_fault  = (acc_addr[1:0] != 2'b00) || ({1'b0, acc_addr} >= ADDR_LIMIT);
  // Writes are suppressed while reset is asserted, so an abandoned store never lands.
  assign mem_we     = reset && enter_resp && acc_write && !acc_fault;

  // State register and wait counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request at the accept edge; later input changes are ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_reg  <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
    end else if (accept) begin
      addr_reg  <= req_addr;
      write_reg <= req_write;
      wdata_reg <= req_wdata;
    end
  end

  // Response qualifiers: both are set only for the single RESP cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_error_reg <= 1'b0;
      rsp_rd_ok_reg <= 1'b0;
    end else begin
      rsp_error_reg <= enter_resp && acc_fault;
      rsp_rd_ok_reg <= enter_resp && !acc_write && !acc_fault;
    end
  end

  // Word RAM with registered read; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_array[acc_idx] <= acc_wdata;
    end
    if (enter_resp) begin
      ram_rdata_reg <= mem_array[acc_idx];
    end
  end

  assign req_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign rsp_valid = (state_reg == ST_RESP);
  assign rsp_error = rsp_error_reg;
  // Read data is shown only for a successful read. It is zero at all other times.
  assign rsp_rdata = rsp_rd_ok_reg ? ram_rdata_reg : '0;

endmodule
